// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types, widths and helpers for the MIPS fetch path
package mips_pkg;

  localparam int INSTR_W      = 32;
  localparam int JUMP_FIELD_W = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips_next_pc.sv
// rtl/mips_next_pc.sv - combinational next-PC and redirect decision for a consumed instruction
module mips_next_pc
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0]       pc,
  input  logic                    branch,
  input  logic                    zero,
  input  logic [31:0]             seimm,
  input  logic                    jump,
  input  logic [JUMP_FIELD_W-1:0] jump_value,
  output logic [ADDR_W-1:0]       next_pc,
  output logic                    taken
);

  logic [ADDR_W-1:0] pc4;
  logic [31:0]       pc4_w;
  logic [31:0]       jump_w;
  logic [31:0]       branch_w;
  logic              unused_bits;

  assign pc4      = pc + ADDR_W'(4);
  assign pc4_w    = 32'(pc4);
  // Targets are formed at full 32-bit width, then cut down to the PC width.
  assign jump_w   = word_align({pc4_w[31:28], jump_value, 2'b00});
  assign branch_w = pc4_w + (seimm << 2);

  assign taken   = jump | (branch & zero);
  assign next_pc = jump            ? jump_w[ADDR_W-1:0]   :
                   (branch & zero) ? branch_w[ADDR_W-1:0] : pc4;

  assign unused_bits = ^{jump_w, branch_w};

endmodule

// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - PC sequencer and instruction fetch with valid/ready output register
// Define MIPS_FETCH_PREFETCH_EN to add a 1-entry prefetch buffer that keeps fetching while decode stalls.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    imem_req,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic                    imem_ack,
  input  logic [INSTR_W-1:0]      imem_rdata,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [INSTR_W-1:0]      instr,
  output logic [ADDR_W-1:0]       instr_pc,
  input  logic                    Branch,
  input  logic                    Zero,
  input  logic [31:0]             SEImm,
  input  logic                    Jump,
  input  logic [JUMP_FIELD_W-1:0] JumpValue,
  output logic                    redirect
);

  localparam logic [ADDR_W-1:0] RST_PC = RESET_PC[ADDR_W-1:0];

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pend_pc;
  logic [ADDR_W-1:0] target;
  logic              inflight;
  logic              discard;
  logic              taken;
  logic              consume;
  logic              redirect_now;
  logic              ack_fire;
  logic              stale;
  logic              accept;
  logic              out_free;
  logic              can_issue;

`ifdef MIPS_FETCH_PREFETCH_EN
  logic               pbuf_valid;
  logic [INSTR_W-1:0] pbuf_instr;
  logic [ADDR_W-1:0]  pbuf_pc;
`endif

  mips_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc         (instr_pc),
    .branch     (Branch),
    .zero       (Zero),
    .seimm      (SEImm),
    .jump       (Jump),
    .jump_value (JumpValue),
    .next_pc    (target),
    .taken      (taken)
  );

  assign consume      = instr_valid & instr_ready;
  assign redirect_now = consume & taken;
  assign out_free     = !instr_valid || instr_ready;
  assign ack_fire     = imem_req & imem_ack;
  // A response is stale if its request predates a redirect.
  assign stale        = discard | redirect_now;
  assign accept       = ack_fire & !stale;

`ifdef MIPS_FETCH_PREFETCH_EN
  assign can_issue = 1'b1;
`else
  assign can_issue = out_free;
`endif

  // Once raised, the request is held by inflight so imem_addr stays put until ack.
  assign imem_req  = (state == REQ) && (inflight || can_issue);
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
`ifdef MIPS_FETCH_PREFETCH_EN
        if (accept && !out_free) state_next = HOLD;
`endif
      end
      HOLD: if (consume) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RST_PC;
      pend_pc     <= RST_PC;
      inflight    <= 1'b0;
      discard     <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      redirect    <= 1'b0;
`ifdef MIPS_FETCH_PREFETCH_EN
      pbuf_valid  <= 1'b0;
      pbuf_instr  <= '0;
      pbuf_pc     <= '0;
`endif
    end else begin
      redirect <= redirect_now;

      if (ack_fire) begin
        inflight <= 1'b0;
        discard  <= 1'b0;
        if (stale) fetch_pc <= redirect_now ? target : pend_pc;
        else       fetch_pc <= fetch_pc + ADDR_W'(4);
      end else begin
        if (imem_req) inflight <= 1'b1;
        // Let the outstanding request finish; park the target until its ack.
        if (redirect_now && imem_req) begin
          discard <= 1'b1;
          pend_pc <= target;
        end else if (redirect_now) begin
          fetch_pc <= target;
        end
      end

      if (accept && out_free) begin
        instr_valid <= 1'b1;
        instr       <= imem_rdata;
        instr_pc    <= fetch_pc;
      end
`ifdef MIPS_FETCH_PREFETCH_EN
      else if (accept) begin
        pbuf_valid <= 1'b1;
        pbuf_instr <= imem_rdata;
        pbuf_pc    <= fetch_pc;
      end else if (consume && pbuf_valid && !redirect_now) begin
        instr      <= pbuf_instr;
        instr_pc   <= pbuf_pc;
        pbuf_valid <= 1'b0;
      end
`endif
      else if (consume) begin
        instr_valid <= 1'b0;
      end

`ifdef MIPS_FETCH_PREFETCH_EN
      if (redirect_now) pbuf_valid <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb/tb_mips_fetch_unit.sv - randomized self-checking bench for mips_fetch_unit against a program-order model
module tb_mips_fetch_unit;

  localparam int AW    = 8;
  localparam int AMASK = (1 << AW) - 1;

  logic          clk, reset;
  logic          imem_req, imem_ack;
  logic [AW-1:0] imem_addr, instr_pc;
  logic [31:0]   imem_rdata, instr, SEImm;
  logic          instr_valid, instr_ready;
  logic          Branch, Zero, Jump, redirect;
  logic [25:0]   JumpValue;

  typedef struct { int pc; bit j; bit b; bit z; int imm; int jv; } ctl_t;
  typedef struct { int pc; logic [31:0] ins; int cyc; bit j; bit b; bit z; int imm; int jv; bit red; } cons_t;

  ctl_t  ov_q[$];
  cons_t got[$];
  int    total, bad, cyc, proto_err, hold_err, redir_cnt, lat_mode, mcnt;
  bit    mbusy, rand_rdy, rand_ctl, spurious_ack, timed_out, was_consume;
  logic [AW-1:0] maddr;

  mips_fetch_unit #(.ADDR_W(AW), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .Branch(Branch), .Zero(Zero), .SEImm(SEImm), .Jump(Jump), .JumpValue(JumpValue),
    .redirect(redirect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] memf(input int a);
    return 32'h5A5A_0000 | 32'(a & AMASK);
  endfunction

  // Architectural next PC: what the program counter should be after this instruction.
  function automatic int ref_next(input int pc, input bit j, input bit b, input bit z,
                                  input int imm, input int jv);
    int pc4;
    pc4 = (pc + 4) & AMASK;
    if (j) return (jv * 4) & AMASK;
    if (b && z) return (pc4 + imm * 4) & AMASK;
    return pc4;
  endfunction

  function automatic ctl_t mk_ctl(input int pc, input bit j, input bit b, input bit z,
                                  input int imm, input int jv);
    ctl_t o;
    o.pc = pc; o.j = j; o.b = b; o.z = z; o.imm = imm; o.jv = jv;
    return o;
  endfunction

  task automatic mem_eval();
    #1;
    if (imem_req) begin
      if (!mbusy) begin
        mbusy = 1'b1;
        maddr = imem_addr;
        mcnt  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        if (imem_addr[1:0] != 2'b00) proto_err++;
      end else if (imem_addr !== maddr) begin
        proto_err++;
      end
      if (mcnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = memf(int'(imem_addr));
        mbusy      = 1'b0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        mcnt--;
      end
    end else begin
      if (mbusy) proto_err++;
      mbusy      = 1'b0;
      imem_ack   = spurious_ack;
      imem_rdata = 32'hBAD0_BAD0;
    end
  endtask

  // One clock of stimulus; entered and left just after a rising edge.
  task automatic step();
    bit          hit, stall;
    logic [31:0] pi;
    logic [AW-1:0] pp;
    cons_t       c;
    instr_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (rand_ctl) begin
      Jump      = ($urandom_range(0, 7) == 0);
      Branch    = ($urandom_range(0, 3) == 0);
      Zero      = 1'($urandom_range(0, 1));
      SEImm     = int'($urandom_range(0, 31)) - 16;
      JumpValue = 26'($urandom);
    end else begin
      Jump = 1'b0; Branch = 1'b0; Zero = 1'b0; SEImm = '0; JumpValue = '0;
    end
    hit = 1'b0;
    if (ov_q.size() > 0 && instr_valid && int'(instr_pc) == ov_q[0].pc) begin
      hit       = 1'b1;
      Jump      = ov_q[0].j;
      Branch    = ov_q[0].b;
      Zero      = ov_q[0].z;
      SEImm     = ov_q[0].imm;
      JumpValue = 26'(ov_q[0].jv);
    end
    mem_eval();
    was_consume = instr_valid && instr_ready;
    if (was_consume && hit) void'(ov_q.pop_front());
    stall = instr_valid && !instr_ready;
    pi = instr;
    pp = instr_pc;
    c.pc = int'(instr_pc); c.ins = instr; c.cyc = cyc;
    c.j = Jump; c.b = Branch; c.z = Zero; c.imm = SEImm; c.jv = int'(JumpValue); c.red = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    if (stall && (!instr_valid || instr !== pi || instr_pc !== pp)) hold_err++;
    if (redirect) redir_cnt++;
    if (was_consume) begin
      c.red = redirect;
      got.push_back(c);
    end
  endtask

  task automatic run_until(input int n, input int budget);
    got.delete();
    redir_cnt = 0;
    for (int k = 0; k < budget && got.size() < n; k++) step();
    timed_out = (got.size() < n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_ack = 1'b0; imem_rdata = '0; mbusy = 1'b0; spurious_ack = 1'b0;
    instr_ready = 1'b0;
    Branch = 1'b0; Zero = 1'b0; Jump = 1'b0; SEImm = '0; JumpValue = '0;
    ov_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b1;
    Branch = 1'b0; Zero = 1'b0; Jump = 1'b0; SEImm = '0; JumpValue = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (imem_req !== 1'b0)    begin bad++; $display("FAIL rst_imem_req got=%b want=0", imem_req); end
    total++; if (imem_addr !== 8'h00)  begin bad++; $display("FAIL rst_imem_addr got=%h want=00", imem_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_instr_valid got=%b want=0", instr_valid); end
    total++; if (instr !== 32'h0)      begin bad++; $display("FAIL rst_instr got=%h want=0", instr); end
    total++; if (instr_pc !== 8'h00)   begin bad++; $display("FAIL rst_instr_pc got=%h want=00", instr_pc); end
    total++; if (redirect !== 1'b0)    begin bad++; $display("FAIL rst_redirect got=%b want=0", redirect); end
  endtask

  task automatic test_sequential();
    lat_mode = 0; rand_rdy = 1'b0; rand_ctl = 1'b0; proto_err = 0;
    do_reset();
    run_until(6, 40);
    total++; if (timed_out) begin bad++; $display("FAIL seq_timeout got=%0d want=6 consumes", got.size()); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= got.size()) begin
        bad++; $display("FAIL seq_pc[%0d] got=none want=%0h", i, 4 * i);
      end else if (got[i].pc != 4 * i || got[i].ins !== memf(4 * i) || got[i].cyc != got[0].cyc + i) begin
        bad++;
        $display("FAIL seq_pc[%0d] got=pc %0h ins %h cyc %0d want=pc %0h ins %h cyc %0d",
                 i, got[i].pc, got[i].ins, got[i].cyc, 4 * i, memf(4 * i), got[0].cyc + i);
      end
    end
    total++; if (proto_err != 0) begin bad++; $display("FAIL seq_protocol got=%0d errors want=0", proto_err); end
  endtask

  task automatic test_branch();
    int want_q[$];
    lat_mode = 0; rand_rdy = 1'b0; rand_ctl = 1'b0;
    do_reset();
    ov_q.push_back(mk_ctl('h10, 1'b0, 1'b1, 1'b1, -1, 0));
    ov_q.push_back(mk_ctl('h10, 1'b0, 1'b1, 1'b0, -1, 0));
    want_q = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h10, 'h14, 'h18};
    run_until(want_q.size(), 80);
    for (int i = 0; i < want_q.size(); i++) begin
      total++;
      if (i >= got.size() || got[i].pc != want_q[i]) begin
        bad++; $display("FAIL branch_pc[%0d] got=%0h want=%0h", i, (i < got.size()) ? got[i].pc : -1, want_q[i]);
      end
    end
    total++; if (redir_cnt != 1) begin bad++; $display("FAIL branch_redirects got=%0d want=1", redir_cnt); end
    total++;
    if (got.size() < 6 || got[4].red != 1'b1 || got[5].red != 1'b0) begin
      bad++; $display("FAIL branch_redirect_pos got=%0d consumes want=pulse after 5th only", got.size());
    end
  endtask

  task automatic test_jump();
    int want_q[$];
    lat_mode = 0; rand_rdy = 1'b0; rand_ctl = 1'b0;
    do_reset();
    ov_q.push_back(mk_ctl('h08, 1'b1, 1'b1, 1'b1, 5, 'h20));
    want_q = '{'h00, 'h04, 'h08, 'h80, 'h84};
    run_until(want_q.size(), 60);
    for (int i = 0; i < want_q.size(); i++) begin
      total++;
      if (i >= got.size() || got[i].pc != want_q[i]) begin
        bad++; $display("FAIL jump_pc[%0d] got=%0h want=%0h", i, (i < got.size()) ? got[i].pc : -1, want_q[i]);
      end
    end
    total++; if (redir_cnt != 1) begin bad++; $display("FAIL jump_redirects got=%0d want=1", redir_cnt); end
  endtask

  task automatic test_wrap();
    int want_q[$];
    lat_mode = 0; rand_rdy = 1'b0; rand_ctl = 1'b0;
    do_reset();
    ov_q.push_back(mk_ctl('h00, 1'b1, 1'b0, 1'b0, 0, 'h3F));
    want_q = '{'h00, 'hFC, 'h00, 'h04};
    run_until(want_q.size(), 60);
    for (int i = 0; i < want_q.size(); i++) begin
      total++;
      if (i >= got.size() || got[i].pc != want_q[i] || got[i].ins !== memf(want_q[i])) begin
        bad++; $display("FAIL wrap_pc[%0d] got=%0h want=%0h", i, (i < got.size()) ? got[i].pc : -1, want_q[i]);
      end
    end
    total++; if (redir_cnt != 1) begin bad++; $display("FAIL wrap_redirects got=%0d want=1", redir_cnt); end
  endtask

  task automatic test_latency_redirect();
    int want_q[$];
    lat_mode = 3; rand_rdy = 1'b0; rand_ctl = 1'b0; proto_err = 0;
    do_reset();
    ov_q.push_back(mk_ctl('h08, 1'b1, 1'b0, 1'b0, 0, 'h10));
    want_q = '{'h00, 'h04, 'h08, 'h40, 'h44};
    run_until(want_q.size(), 120);
    for (int i = 0; i < want_q.size(); i++) begin
      total++;
      if (i >= got.size() || got[i].pc != want_q[i] || got[i].ins !== memf(want_q[i])) begin
        bad++;
        $display("FAIL latredir_pc[%0d] got=pc %0h ins %h want=pc %0h ins %h", i,
                 (i < got.size()) ? got[i].pc : -1, (i < got.size()) ? got[i].ins : 32'h0,
                 want_q[i], memf(want_q[i]));
      end
    end
    total++; if (redir_cnt != 1) begin bad++; $display("FAIL latredir_redirects got=%0d want=1", redir_cnt); end
    total++; if (proto_err != 0) begin bad++; $display("FAIL latredir_protocol got=%0d errors want=0", proto_err); end
  endtask

  task automatic test_reset_mid();
    lat_mode = 3; rand_rdy = 1'b0; rand_ctl = 1'b0;
    do_reset();
    for (int k = 0; k < 20 && !(imem_req && mbusy); k++) step();
    total++; if (!(imem_req && mbusy)) begin bad++; $display("FAIL rstmid_setup got=req %b want=pending request", imem_req); end
    #2;
    reset = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hBAD0_0001;
    #1;
    total++; if (imem_req !== 1'b0)    begin bad++; $display("FAIL rstmid_req got=%b want=0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", instr_valid); end
    mbusy = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    spurious_ack = 1'b1;
    step();
    spurious_ack = 1'b0;
    run_until(2, 40);
    total++;
    if (got.size() < 2 || got[0].pc != 0 || got[0].ins !== memf(0) || got[1].pc != 4) begin
      bad++;
      $display("FAIL rstmid_first got=%0d consumes first pc %0h ins %h want=pc 0 ins %h then 4",
               got.size(), (got.size() > 0) ? got[0].pc : -1, (got.size() > 0) ? got[0].ins : 32'h0, memf(0));
    end
  endtask

  task automatic test_random();
    int  want_pc;
    bit  want_red;
    lat_mode = -1; rand_rdy = 1'b1; rand_ctl = 1'b1; proto_err = 0; hold_err = 0;
    do_reset();
    run_until(200, 4000);
    total++; if (timed_out) begin bad++; $display("FAIL rand_timeout got=%0d want=200 consumes", got.size()); end
    want_pc = 0;
    for (int i = 0; i < got.size(); i++) begin
      want_red = got[i].j | (got[i].b & got[i].z);
      total++;
      if (got[i].pc != want_pc || got[i].ins !== memf(want_pc) || got[i].red != want_red) begin
        bad++;
        $display("FAIL rand_consume[%0d] got=pc %0h ins %h red %b want=pc %0h ins %h red %b",
                 i, got[i].pc, got[i].ins, got[i].red, want_pc, memf(want_pc), want_red);
        break;
      end
      want_pc = ref_next(want_pc, got[i].j, got[i].b, got[i].z, got[i].imm, got[i].jv);
    end
    total++; if (proto_err != 0) begin bad++; $display("FAIL rand_protocol got=%0d errors want=0", proto_err); end
    total++; if (hold_err != 0)  begin bad++; $display("FAIL rand_stall_hold got=%0d changes want=0", hold_err); end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; proto_err = 0; hold_err = 0; redir_cnt = 0;
    lat_mode = 0; mcnt = 0; mbusy = 1'b0; rand_rdy = 1'b0; rand_ctl = 1'b0;
    spurious_ack = 1'b0; timed_out = 1'b0; was_consume = 1'b0; maddr = '0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_wrap();
    test_latency_redirect();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
